// File: rtl/msi_arbiter.sv
// msi_arbiter: latches rising edges of level interrupt sources and shares one
// MSI request/grant port among them round-robin, with a hold-off gap between MSIs.
module msi_arbiter #(
  parameter int N_SRC       = 4,
  parameter int VEC_W       = 5,
  parameter int HOLDOFF_CYC = 16
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic [N_SRC-1:0] irq_i,
  input  logic [N_SRC-1:0] irq_mask_i,
  input  logic             msi_enabled,
  input  logic [2:0]       msi_vector_width,
  output logic             msi_request,
  input  logic             msi_grant,
  output logic [VEC_W-1:0] msi_vector_num,
  output logic [N_SRC-1:0] pending_o,
  output logic [15:0]      sent_count_o,
  output logic             busy_o
);

  localparam int IDX_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;
  localparam int CNT_W = (HOLDOFF_CYC > 1) ? $clog2(HOLDOFF_CYC) : 1;
  localparam logic [IDX_W-1:0] LAST_INIT = IDX_W'(N_SRC - 1);
  localparam logic [CNT_W-1:0] HOLD_INIT = (HOLDOFF_CYC > 0) ? CNT_W'(HOLDOFF_CYC - 1) : '0;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    HOLDOFF = 2'd2
  } state_t;

  state_t state_reg;
  state_t state_next;

  logic [N_SRC-1:0] irq_p_reg;
  logic [N_SRC-1:0] pending_reg;
  logic [N_SRC-1:0] pending_next;
  logic [N_SRC-1:0] rise;
  logic [N_SRC-1:0] clr;
  logic [N_SRC-1:0] eligible;
  logic [IDX_W-1:0] idx_reg;
  logic [IDX_W-1:0] last_reg;
  logic [VEC_W-1:0] vec_reg;
  logic [15:0]      sent_reg;
  logic [CNT_W-1:0] hold_cnt_reg;

  logic             pick_found;
  logic [IDX_W-1:0] pick_idx;
  logic [IDX_W-1:0] cand;
  logic             load;
  logic             grant_fire;

  // Vectors beyond the allocated range fold onto vector 0.
  function automatic logic [VEC_W-1:0] map_vec(input logic [IDX_W-1:0] i,
                                               input logic [2:0] w);
    logic [2:0] wc;
    logic [5:0] alloc;
    wc    = (w > 3'd5) ? 3'd5 : w;
    alloc = 6'd1 << wc;
    return (6'(i) < alloc) ? VEC_W'(i) : '0;
  endfunction

  // Set wins over clear so an edge arriving with its own grant is not lost.
  for (genvar gi = 0; gi < N_SRC; gi++) begin : g_src
    assign rise[gi]         = irq_i[gi] & ~irq_p_reg[gi];
    assign clr[gi]          = grant_fire & (idx_reg == IDX_W'(gi));
    assign pending_next[gi] = rise[gi] | (pending_reg[gi] & ~clr[gi]);
    assign eligible[gi]     = pending_reg[gi] & ~irq_mask_i[gi];
  end

  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int k = 0; k < N_SRC; k++) begin
      cand = IDX_W'((int'(last_reg) + 1 + k) % N_SRC);
      if (!pick_found && eligible[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  assign load       = (state_reg == IDLE) && msi_enabled && pick_found;
  assign grant_fire = (state_reg == REQ) && msi_grant;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (msi_enabled && pick_found) begin
          state_next = REQ;
        end
      end
      REQ: begin
        if (msi_grant) begin
          state_next = (HOLDOFF_CYC == 0) ? IDLE : HOLDOFF;
        end else if (!msi_enabled) begin
          state_next = IDLE;
        end
      end
      HOLDOFF: begin
        if (hold_cnt_reg == '0) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    msi_request = (state_reg == REQ);
    busy_o      = (state_reg != IDLE);
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      irq_p_reg    <= '0;
      pending_reg  <= '0;
      idx_reg      <= '0;
      last_reg     <= LAST_INIT;
      vec_reg      <= '0;
      sent_reg     <= '0;
      hold_cnt_reg <= '0;
    end else begin
      irq_p_reg   <= irq_i;
      pending_reg <= pending_next;
      // Vector is frozen at selection time so it stays stable through REQ.
      if (load) begin
        idx_reg <= pick_idx;
        vec_reg <= map_vec(pick_idx, msi_vector_width);
      end
      if (grant_fire) begin
        last_reg     <= idx_reg;
        sent_reg     <= sent_reg + 16'd1;
        hold_cnt_reg <= HOLD_INIT;
      end else if ((state_reg == HOLDOFF) && (hold_cnt_reg != '0)) begin
        hold_cnt_reg <= hold_cnt_reg - 1'b1;
      end
    end
  end

  assign msi_vector_num = vec_reg;
  assign pending_o      = pending_reg;
  assign sent_count_o   = sent_reg;

endmodule
